// File: rtl/afifo_burst_tx_pkg.sv
// Shared definitions for the afifo burst packetizer (write side) and its
// read-side word decoder: word kind tags, FSM states, header field offsets.
package afifo_burst_tx_pkg;

  // Word kind tag carried in the two MSBs of every afifo word.
  localparam logic [1:0] KIND_HDR  = 2'b01;
  localparam logic [1:0] KIND_DATA = 2'b10;
  localparam logic [1:0] KIND_LAST = 2'b11;

  // Header payload is {len, addr}; len is the top LEN_W bits of the payload.
  localparam int LEN_W       = 4;
  localparam int AFIFODW_DEF = 32;
  localparam int LEN_MSB     = AFIFODW_DEF - 1;
  localparam int LEN_LSB     = AFIFODW_DEF - LEN_W;

  // FSM state encodings kept as plain constants for older decoders.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_DATA = 1'b1;

  typedef enum logic [0:0] {
    IDLE = ST_IDLE,
    DATA = ST_DATA
  } state_e;

  // Kind tag of a data beat given the beats still remaining after it.
  function automatic logic [1:0] beat_kind(input logic [LEN_W-1:0] rem);
    return (rem == '0) ? KIND_LAST : KIND_DATA;
  endfunction

endpackage

// File: rtl/afifo_burst_tx.sv
// Write-clock-domain packetizer: turns a burst command plus its data beats
// into a stream of tagged afifo words (one header, then len+1 data words,
// the final one tagged LAST). A single output stage register decouples the
// handshakes from afifo full; a held word is never dropped or repeated.
module afifo_burst_tx
  import afifo_burst_tx_pkg::*;
#(
  parameter int AFIFODW = 32
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [AFIFODW-5:0]   cmd_addr,
  input  logic [3:0]           cmd_len,
  input  logic                 dat_valid,
  output logic                 dat_ready,
  input  logic [AFIFODW-1:0]   dat_data,
  output logic                 wen,
  input  logic                 wqfull,
  output logic [AFIFODW+1:0]   wdata,
  output logic                 busy,
  output logic [15:0]          pkt_cnt
);

  localparam int WW = AFIFODW + 2;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             out_vld_q, out_vld_d;
  logic [WW-1:0]    out_word_q, out_word_d;
  logic [15:0]      pkt_cnt_q;

  logic stage_free;
  logic cmd_fire;
  logic dat_fire;
  logic last_push;

  // The stored word leaves whenever afifo is not full; the stage can take a
  // new word in the same cycle it empties, so bursts run gap-free.
  assign wen        = out_vld_q & ~wqfull;
  assign wdata      = out_word_q;
  assign stage_free = ~out_vld_q | wen;

  assign cmd_ready = (state_q == IDLE) & stage_free;
  assign dat_ready = (state_q == DATA) & stage_free;
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign dat_fire  = dat_valid & dat_ready;

  assign busy      = (state_q != IDLE) | out_vld_q;
  assign last_push = wen & (out_word_q[WW-1 -: 2] == KIND_LAST);
  assign pkt_cnt   = pkt_cnt_q;

  // Next state for the FSM, beat counter and output stage.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    out_vld_d  = out_vld_q & ~wen;
    out_word_d = out_word_q;
    if (cmd_fire) begin
      out_vld_d  = 1'b1;
      out_word_d = {KIND_HDR, cmd_len, cmd_addr};
      rem_d      = cmd_len;
      state_d    = DATA;
    end else if (dat_fire) begin
      out_vld_d  = 1'b1;
      out_word_d = {beat_kind(rem_q), dat_data};
      if (rem_q == '0) begin
        state_d = IDLE;
      end else begin
        rem_d = rem_q - 4'd1;
      end
    end
  end

  // State registers; reset discards any partial burst.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      out_vld_q  <= 1'b0;
      out_word_q <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      out_vld_q  <= out_vld_d;
      out_word_q <= out_word_d;
    end
  end

  // Completed-burst counter, bumped as each LAST word enters afifo.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      pkt_cnt_q <= '0;
    end else if (last_push) begin
      pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end
  end

endmodule
